pc_gen: RTL and testbench

Parametrised next-PC generator sitting between fetch and execute. It owns the architectural fetch PC register and predicts the next fetch address with a direct-mapped branch target table of 2-bit counters. It resolves the true next PC of each executed instruction from `pc_ctl`, and issues a redirect with a registered PC reload on mispredict, trap or `mret`. It also maintains a redirect performance counter.

---
 rtl/pc_gen.sv | 184 ++++++++++++++++++
 tb/tb_pc_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch PC register, 2-bit-counter branch target table predictor
//            and execute-stage next-PC resolution with redirect counting.
// Options  : PC_BHT_EN - define to build the predictor table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter int              BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pred_npc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pred_npc,
  input  logic [2:0]      ex_pc_ctl,
  input  logic            ex_alu_o,
  input  logic [XLEN-1:0] ex_reg1,
  input  logic [XLEN-1:0] ex_offset,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] mtvec,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     redirect_cnt
);

  localparam int IDX = $clog2(BHT_DEPTH);

  localparam logic [2:0] PC_SNPC  = 3'd0;
  localparam logic [2:0] PC_J_PC  = 3'd1;
  localparam logic [2:0] PC_J_REG = 3'd2;
  localparam logic [2:0] PC_B     = 3'd3;
  localparam logic [2:0] PC_B_INV = 3'd4;
  localparam logic [2:0] PC_EPC   = 3'd5;
  localparam logic [2:0] PC_TRAP  = 3'd6;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     redirect_cnt_q, redirect_cnt_d;

  logic [XLEN-1:0] snpc, br_target, dnpc;
  logic            is_branch, br_taken, is_jal;

  always_comb begin
    snpc      = ex_pc + XLEN'(4);
    br_target = ex_pc + ex_offset;
    dnpc      = snpc;
    is_branch = 1'b0;
    br_taken  = 1'b0;
    is_jal    = 1'b0;
    case (ex_pc_ctl)
      PC_SNPC:  dnpc = snpc;
      PC_J_PC: begin
        is_jal = 1'b1;
        dnpc   = br_target;
      end
      PC_J_REG: dnpc = ex_reg1 + ex_offset;
      PC_B: begin
        is_branch = 1'b1;
        br_taken  = ex_alu_o;
        dnpc      = ex_alu_o ? br_target : snpc;
      end
      PC_B_INV: begin
        is_branch = 1'b1;
        br_taken  = !ex_alu_o;
        dnpc      = !ex_alu_o ? br_target : snpc;
      end
      PC_EPC:   dnpc = epc;
      PC_TRAP:  dnpc = mtvec;
      default:  dnpc = snpc;
    endcase
  end

  assign redirect    = ex_valid && (dnpc != ex_pred_npc);
  assign redirect_pc = dnpc;

`ifdef PC_BHT_EN
  localparam int TAG_W = XLEN - IDX - 2;

  logic             bht_valid_q  [BHT_DEPTH];
  logic [TAG_W-1:0] bht_tag_q    [BHT_DEPTH];
  logic [XLEN-1:0]  bht_target_q [BHT_DEPTH];
  logic [1:0]       bht_ctr_q    [BHT_DEPTH];

  logic [IDX-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             bht_we;
  logic [1:0]       bht_ctr_d;

  always_comb begin
    if_idx        = if_pc[IDX+1:2];
    if_tag        = if_pc[XLEN-1:IDX+2];
    if_hit        = bht_valid_q[if_idx] && (bht_tag_q[if_idx] == if_tag);
    if_pred_taken = if_hit && bht_ctr_q[if_idx][1];
    if_pred_npc   = if_pred_taken ? bht_target_q[if_idx] : if_pc + XLEN'(4);
  end

  // Branches train the counter on a hit and allocate weakly on a miss.
  always_comb begin
    ex_idx    = ex_pc[IDX+1:2];
    ex_tag    = ex_pc[XLEN-1:IDX+2];
    ex_hit    = bht_valid_q[ex_idx] && (bht_tag_q[ex_idx] == ex_tag);
    bht_we    = 1'b0;
    bht_ctr_d = bht_ctr_q[ex_idx];
    if (ex_valid && is_branch) begin
      bht_we = 1'b1;
      if (!ex_hit) begin
        bht_ctr_d = br_taken ? 2'b10 : 2'b01;
      end else if (br_taken) begin
        bht_ctr_d = (bht_ctr_q[ex_idx] == 2'b11) ? 2'b11 : bht_ctr_q[ex_idx] + 2'd1;
      end else begin
        bht_ctr_d = (bht_ctr_q[ex_idx] == 2'b00) ? 2'b00 : bht_ctr_q[ex_idx] - 2'd1;
      end
    end else if (ex_valid && is_jal) begin
      bht_we    = 1'b1;
      bht_ctr_d = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_valid_q[i]  <= 1'b0;
        bht_tag_q[i]    <= '0;
        bht_target_q[i] <= '0;
        bht_ctr_q[i]    <= 2'b00;
      end
    end else if (bht_we) begin
      bht_valid_q[ex_idx]  <= 1'b1;
      bht_tag_q[ex_idx]    <= ex_tag;
      bht_target_q[ex_idx] <= br_target;
      bht_ctr_q[ex_idx]    <= bht_ctr_d;
    end
  end
`else
  logic [IDX:0] unused_bht;

  assign if_pred_taken = 1'b0;
  assign if_pred_npc   = if_pc + XLEN'(4);
  assign unused_bht    = {{IDX{1'b0}}, is_branch ^ br_taken ^ is_jal};
`endif

  // A redirect overrides any fetch handshake in the same cycle.
  always_comb begin
    if_valid_d     = 1'b1;
    pc_d           = pc_q;
    redirect_cnt_d = redirect_cnt_q;
    if (redirect) begin
      pc_d           = redirect_pc;
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    end else if (if_valid_q && if_ready) begin
      pc_d = if_pred_npc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      if_valid_q     <= 1'b0;
      redirect_cnt_q <= 32'd0;
    end else begin
      pc_q           <= pc_d;
      if_valid_q     <= if_valid_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign if_pc        = pc_q;
  assign if_valid     = if_valid_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
`default_nettype none
`timescale 1ns/1ps

module tb_pc_gen;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 64;
  localparam int          IDX      = $clog2(DEPTH);

  localparam logic [2:0] C_SNPC = 3'd0, C_JPC = 3'd1, C_JREG = 3'd2, C_B = 3'd3,
                         C_BINV = 3'd4, C_EPC = 3'd5, C_TRAP = 3'd6;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_valid, if_ready = 1'b0, if_pred_taken;
  logic [31:0] if_pc, if_pred_npc;
  logic        ex_valid = 1'b0, ex_alu_o = 1'b0;
  logic [31:0] ex_pc = '0, ex_pred_npc = '0, ex_reg1 = '0, ex_offset = '0, epc = '0, mtvec = '0;
  logic [2:0]  ex_pc_ctl = 3'd0;
  logic        redirect;
  logic [31:0] redirect_pc, redirect_cnt;

  pc_gen #(.XLEN(XLEN), .RESET_PC(RESET_PC), .BHT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_pred_npc(if_pred_npc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_npc(ex_pred_npc), .ex_pc_ctl(ex_pc_ctl),
    .ex_alu_o(ex_alu_o), .ex_reg1(ex_reg1), .ex_offset(ex_offset), .epc(epc), .mtvec(mtvec),
    .redirect(redirect), .redirect_pc(redirect_pc), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_cnt;
  logic        m_ifv;
  bit          m_v   [DEPTH];
  logic [31:0] m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_ctr [DEPTH];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] resolve();
    case (ex_pc_ctl)
      C_JPC:   return ex_pc + ex_offset;
      C_JREG:  return ex_reg1 + ex_offset;
      C_B:     return ex_alu_o ? ex_pc + ex_offset : ex_pc + 32'd4;
      C_BINV:  return !ex_alu_o ? ex_pc + ex_offset : ex_pc + 32'd4;
      C_EPC:   return epc;
      C_TRAP:  return mtvec;
      default: return ex_pc + 32'd4;
    endcase
  endfunction

  // Returns {taken, npc}.
  function automatic logic [32:0] predict(input logic [31:0] pc);
`ifdef PC_BHT_EN
    int s;
    s = slot(pc);
    if (m_v[s] && m_tag[s] == (pc >> (IDX + 2)) && m_ctr[s] >= 2) return {1'b1, m_tgt[s]};
`endif
    return {1'b0, pc + 32'd4};
  endfunction

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_ifv = 1'b0;
    m_cnt = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] d;
    logic [32:0] p;
    bit          red;
    d   = resolve();
    p   = predict(m_pc);
    red = ex_valid && (d != ex_pred_npc);
`ifdef PC_BHT_EN
    begin
      int s;
      bit hit, tk;
      s   = slot(ex_pc);
      hit = m_v[s] && m_tag[s] == (ex_pc >> (IDX + 2));
      if (ex_valid && (ex_pc_ctl == C_B || ex_pc_ctl == C_BINV)) begin
        tk = (ex_pc_ctl == C_B) ? ex_alu_o : !ex_alu_o;
        if (!hit)   m_ctr[s] = tk ? 2 : 1;
        else if (tk) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
        else        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        m_v[s] = 1'b1; m_tag[s] = ex_pc >> (IDX + 2); m_tgt[s] = ex_pc + ex_offset;
      end else if (ex_valid && ex_pc_ctl == C_JPC) begin
        m_ctr[s] = 3;
        m_v[s] = 1'b1; m_tag[s] = ex_pc >> (IDX + 2); m_tgt[s] = ex_pc + ex_offset;
      end
    end
`endif
    if (red) m_pc = d;
    else if (m_ifv && if_ready) m_pc = p[31:0];
    if (red) m_cnt = m_cnt + 32'd1;
    m_ifv = 1'b1;
  endtask

  task automatic compare();
    logic [31:0] d;
    logic [32:0] p;
    d = resolve();
    p = predict(m_pc);
    chk("if_valid",      {31'd0, if_valid},      {31'd0, m_ifv});
    chk("if_pc",         if_pc,                  m_pc);
    chk("if_pred_npc",   if_pred_npc,            p[31:0]);
    chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, p[32]});
    chk("redirect",      {31'd0, redirect},      {31'd0, ex_valid && (d != ex_pred_npc)});
    chk("redirect_pc",   redirect_pc,            d);
    chk("redirect_cnt",  redirect_cnt,           m_cnt);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [2:0] ctl, input logic alu, input logic [31:0] pc,
                        input logic [31:0] reg1, input logic [31:0] off, input logic [31:0] pred);
    ex_valid = 1'b1; ex_pc_ctl = ctl; ex_alu_o = alu; ex_pc = pc;
    ex_reg1 = reg1; ex_offset = off; ex_pred_npc = pred;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    set_ex(C_JREG, 1'b0, 32'h8000_0000, t, 32'd0, t + 32'd8);
    cyc();
    ex_valid = 1'b0;
  endtask

  initial begin
    if_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_cnt", redirect_cnt, 32'd0);
    rst_n = 1'b1;

    // Reset release sequence
    cyc(); chk("t1_pc0", if_pc, 32'h8000_0000); chk("t1_valid", {31'd0, if_valid}, 32'd1);
    cyc(); chk("t1_pc1", if_pc, 32'h8000_0004);
    cyc(); chk("t1_pc2", if_pc, 32'h8000_0008); chk("t1_redirect", {31'd0, redirect}, 32'd0);

    // Taken branch mispredicted
    set_ex(C_B, 1'b1, 32'h8000_0010, 32'd0, 32'h40, 32'h8000_0014);
    #1;
    chk("t2_redirect", {31'd0, redirect}, 32'd1);
    chk("t2_redirect_pc", redirect_pc, 32'h8000_0050);
    cyc(); ex_valid = 1'b0;
    chk("t2_if_pc", if_pc, 32'h8000_0050);
    chk("t2_cnt", redirect_cnt, 32'd1);
    redirect_to(32'h8000_0010);
    chk("t2_refetch", if_pc, 32'h8000_0010);
`ifdef PC_BHT_EN
    chk("t2_pred_taken", {31'd0, if_pred_taken}, 32'd1);
    chk("t2_pred_npc", if_pred_npc, 32'h8000_0050);
`else
    chk("t2_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    chk("t2_pred_npc", if_pred_npc, 32'h8000_0014);
`endif

    // Not-taken training, counter saturating at zero
    for (int k = 0; k < 3; k++) begin
      set_ex(C_B, 1'b0, 32'h8000_0010, 32'd0, 32'h40, 32'h8000_0050);
      cyc(); ex_valid = 1'b0;
      redirect_to(32'h8000_0010);
      chk("t3_pred_taken", {31'd0, if_pred_taken}, 32'd0);
      chk("t3_pred_npc", if_pred_npc, 32'h8000_0014);
    end

    // Trap coinciding with a fetch handshake
    set_ex(C_TRAP, 1'b0, 32'h8000_0014, 32'd0, 32'd0, 32'd0);
    mtvec = 32'h8000_0100;
    #1;
    chk("t4_redirect", {31'd0, redirect}, 32'd1);
    cyc(); ex_valid = 1'b0;
    chk("t4_if_pc", if_pc, 32'h8000_0100);

    // Stall, then redirect during the stall
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t5_hold_pc", if_pc, 32'h8000_0100);
      chk("t5_hold_npc", if_pred_npc, 32'h8000_0104);
    end
    redirect_to(32'h8000_0200);
    chk("t5_stall_redirect", if_pc, 32'h8000_0200);
    if_ready = 1'b1;

    // Allocate a strongly-taken jump, then reset while a redirect is high
    set_ex(C_JPC, 1'b0, 32'h8000_0010, 32'd0, 32'h40, 32'h8000_0050);
    cyc(); ex_valid = 1'b0;
    redirect_to(32'h8000_0010);
`ifdef PC_BHT_EN
    chk("t6_pre_taken", {31'd0, if_pred_taken}, 32'd1);
`endif
    set_ex(C_TRAP, 1'b0, 32'h8000_0010, 32'd0, 32'd0, 32'd0);
    mtvec = 32'h8000_0300;
    #1;
    chk("t6_redirect", {31'd0, redirect}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pc", if_pc, RESET_PC);
    chk("t6_rst_cnt", redirect_cnt, 32'd0);
    chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    ex_valid = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc();
    redirect_to(32'h8000_0010);
    chk("t6_miss_taken", {31'd0, if_pred_taken}, 32'd0);
    chk("t6_miss_npc", if_pred_npc, 32'h8000_0014);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst_n     = ($urandom_range(0, 499) != 0);
      if_ready  = ($urandom_range(0, 3) != 0);
      ex_valid  = $urandom_range(0, 1) != 0;
      ex_pc_ctl = 3'($urandom_range(0, 7));
      ex_alu_o  = $urandom_range(0, 1) != 0;
      ex_pc     = ($urandom_range(0, 3) == 0) ? if_pc
                                              : 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      ex_offset = 32'((int'($urandom_range(0, 63)) - 32) * 4);
      ex_reg1   = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      epc       = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      mtvec     = 32'h8000_0400;
      case ($urandom_range(0, 2))
        0:       ex_pred_npc = ex_pc + 32'd4;
        1:       ex_pred_npc = ex_pc + ex_offset;
        default: ex_pred_npc = ($urandom_range(0, 1) != 0) ? epc : mtvec;
      endcase
    end
    cyc();
    rst_n    = 1'b1;
    ex_valid = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
